piso_serializer: RTL

//   Parallel-in serial-out shift register with valid/ready handshakes on both sides.

---
 rtl/piso_pkg.sv | 10 +
 rtl/piso_bit_counter.sv | 29 ++
 rtl/piso_serializer.sv | 85 ++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic {PISO_IDLE, PISO_SHIFT} piso_state_e;

  function automatic int piso_cnt_w(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer; flags the final bit position of a word.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  localparam int CNT_W = piso_cnt_w(DATA_WIDTH)
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shift register with valid/ready on both sides; a new word
// can be loaded on the edge that retires the last bit of the previous one.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  input  logic                  dout_ready
);

  piso_state_e           state, state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  term;
  logic                  load;
  logic                  xfer;
  logic                  xfer_last;
  logic                  out_bit;

  // dout_valid is exactly "a word is in flight", so it is decoded from state.
  assign dout_valid = (state == PISO_SHIFT);
  assign xfer       = dout_valid & dout_ready;
  assign xfer_last  = xfer & term;
  assign din_ready  = resetn & ((state == PISO_IDLE) | xfer_last);
  assign load       = din_valid & din_ready;

  assign out_bit    = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
  assign dout       = resetn & out_bit;
  assign dout_last  = resetn & dout_valid & term;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= PISO_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      PISO_IDLE: begin
        if (load) state_next = PISO_SHIFT;
      end
      PISO_SHIFT: begin
        if (xfer_last && !load) state_next = PISO_IDLE;
      end
      default: state_next = PISO_IDLE;
    endcase
  end

  // The last bit is not shifted out: the register either reloads or idles holding it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (xfer && !term) begin
      if (MSB_FIRST != 0) begin
        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
      end
    end
  end

  piso_bit_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .resetn (resetn),
    .clear  (load),
    .enable (xfer & ~term),
    .last   (term)
  );

endmodule
